gcd_requester: RTL and testbench

Initiator-side front end for the start/done GCD unit. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Issues each pair to the GCD unit with a one-cycle start pulse, captures the result on the first cycle of done, and returns {gcd, a, b} on a valid/ready result stream. Sits between the operand producer (test sequencer or host interface) and the GCD datapath.

---
 rtl/gcd_requester_if.sv | 32 +++
 rtl/gcd_requester.sv | 149 ++++++++++++++
 tb/tb_gcd_requester.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_requester_if.sv
// rtl/gcd_requester_if.sv - operand stream, result stream and GCD-unit start/done bus of gcd_requester
`timescale 1ns/1ps
interface gcd_requester_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_gcd;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_err;
  logic          gcd_start;
  logic [DW-1:0] gcd_a;
  logic [DW-1:0] gcd_b;
  logic          gcd_done;
  logic [DW-1:0] gcd_result;
  logic          busy;

  modport master (
    input  in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
    output in_ready, out_valid, out_gcd, out_a, out_b, out_err,
    output gcd_start, gcd_a, gcd_b, busy
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
    input  in_ready, out_valid, out_gcd, out_a, out_b, out_err,
    input  gcd_start, gcd_a, gcd_b, busy
  );
endinterface

// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - operand FIFO plus start/done sequencer for the GCD unit
// Optional WAIT_DONE abort timer enabled by GCD_REQ_TIMEOUT_EN.
`timescale 1ns/1ps
module gcd_requester #(
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 70000
) (
  input  logic            clk,
  input  logic            rst_n,
  gcd_requester_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gcd_requester: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("gcd_requester: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DRAIN} state_t;

  state_t        state;
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, empty, full;

  logic          start_r, valid_r;
  logic [DW-1:0] ga_r, gb_r, sa_r, sb_r, og_r, oa_r, ob_r;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign push  = bus.in_valid && !full;
  // Registered out_valid gates the pop, so a new issue waits for an empty result register.
  assign pop   = (state == IDLE) && !empty && !valid_r;

  assign bus.in_ready  = !full;
  assign bus.busy      = (state != IDLE) || !empty;
  assign bus.gcd_start = start_r;
  assign bus.gcd_a     = ga_r;
  assign bus.gcd_b     = gb_r;
  assign bus.out_valid = valid_r;
  assign bus.out_gcd   = og_r;
  assign bus.out_a     = oa_r;
  assign bus.out_b     = ob_r;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer;
  logic          err_r;
  assign bus.out_err = err_r;
`else
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_r <= 1'b0;
      ga_r    <= '0;
      gb_r    <= '0;
      sa_r    <= '0;
      sb_r    <= '0;
      valid_r <= 1'b0;
      og_r    <= '0;
      oa_r    <= '0;
      ob_r    <= '0;
`ifdef GCD_REQ_TIMEOUT_EN
      timer   <= '0;
      err_r   <= 1'b0;
`endif
    end else begin
      if (valid_r && bus.out_ready) valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ga_r    <= mem_a[rd_ptr];
            gb_r    <= mem_b[rd_ptr];
            sa_r    <= mem_a[rd_ptr];
            sb_r    <= mem_b[rd_ptr];
            start_r <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          start_r <= 1'b0;
          state   <= WAIT_DONE;
`ifdef GCD_REQ_TIMEOUT_EN
          timer   <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.gcd_done) begin
            og_r    <= bus.gcd_result;
            oa_r    <= sa_r;
            ob_r    <= sb_r;
            valid_r <= 1'b1;
            state   <= DRAIN;
`ifdef GCD_REQ_TIMEOUT_EN
            err_r   <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            og_r    <= '0;
            oa_r    <= sa_r;
            ob_r    <= sb_r;
            err_r   <= 1'b1;
            valid_r <= 1'b1;
            state   <= IDLE;
          end else begin
            timer   <= timer + TW'(1);
`endif
          end
        end
        // Swallow the remaining cycles of a multi-cycle done.
        DRAIN: begin
          if (!bus.gcd_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - randomized self-checking bench for gcd_requester with a behavioural GCD unit
`timescale 1ns/1ps
module tb_gcd_requester;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef GCD_REQ_TIMEOUT_EN
  localparam int TIMEOUT = 10;
`else
  localparam int TIMEOUT = 70000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_requester_if #(.DW(DW)) bus ();

  gcd_requester #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] g;
    logic          err;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[DW-1:0];
  endfunction

  // Behavioural GCD unit: cfg_compute idle cycles after start, then done for cfg_done_w cycles.
  int cfg_compute = 3;
  int cfg_done_w  = 2;
  bit cfg_never   = 1'b0;
  int u_cmp, u_dw;
  bit u_act = 1'b0;
  logic [DW-1:0] u_res;

  initial begin
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        u_act = 1'b0;
        bus.gcd_done = 1'b0;
      end else if (bus.gcd_start) begin
        u_act = !cfg_never;
        u_cmp = cfg_compute;
        u_dw  = cfg_done_w;
        u_res = ref_gcd(bus.gcd_a, bus.gcd_b);
        bus.gcd_done = 1'b0;
      end else if (u_act) begin
        if (u_cmp > 0) u_cmp--;
        else if (u_dw > 0) begin
          bus.gcd_done   = 1'b1;
          bus.gcd_result = u_res;
          u_dw--;
        end else begin
          bus.gcd_done   = 1'b0;
          bus.gcd_result = $urandom;
          u_act = 1'b0;
        end
      end
    end
  end

  int n_starts  = 0;
  int n_results = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.gcd_start) begin
        n_starts++;
        check("start_with_result_pending", bus.out_valid, 1'b0);
        check("start_while_done_high", bus.gcd_done, 1'b0);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        n_results++;
        if (exp_q.size() == 0) check("unexpected_result", 1'b1, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          check("res_gcd", bus.out_gcd, mon_e.g);
          check("res_a",   bus.out_a,   mon_e.a);
          check("res_b",   bus.out_b,   mon_e.b);
          check("res_err", bus.out_err, mon_e.err);
        end
      end
    end
  end

  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t e;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (cfg_never) e = '{a, b, '0, 1'b1};
        else           e = '{a, b, ref_gcd(a, b), 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("push_accept_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.out_valid) return;
      tick(1);
    end
    check("out_valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !bus.busy && !bus.out_valid) return;
      tick(1);
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base_r, base_s;
  logic [DW-1:0] held_g;
  logic [DW-1:0] ra, rb;
  int k;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_gcd_start", bus.gcd_start, 1'b0);
    check("rst_gcd_a",     bus.gcd_a,     '0);
    check("rst_gcd_b",     bus.gcd_b,     '0);
    check("rst_out_gcd",   bus.out_gcd,   '0);
    check("rst_out_a",     bus.out_a,     '0);
    check("rst_out_b",     bus.out_b,     '0);
    check("rst_out_err",   bus.out_err,   1'b0);
    check("rst_busy",      bus.busy,      1'b0);

    // Single pair with start-pulse timing
    cfg_compute = 3; cfg_done_w = 2;
    push(16'd48, 16'd18);
    tick(1);
    check("single_start",  bus.gcd_start, 1'b1);
    check("single_gcd_a",  bus.gcd_a, 16'd48);
    check("single_gcd_b",  bus.gcd_b, 16'd18);
    tick(1);
    check("single_start_one_cycle", bus.gcd_start, 1'b0);
    wait_valid(50);
    check("single_out_gcd", bus.out_gcd, 16'd6);
    check("single_out_a",   bus.out_a,   16'd48);
    check("single_out_b",   bus.out_b,   16'd18);
    check("single_out_err", bus.out_err, 1'b0);
    wait_idle(100);
    check("single_starts",  n_starts,  1);
    check("single_results", n_results, 1);

    // Five pairs, FIFO fills while the first is in flight
    cfg_compute = 8; cfg_done_w = 1;
    base_r = n_results;
    push(16'($urandom_range(1, 5000)), 16'($urandom_range(1, 5000)));
    tick(1);
    check("fill_first_start", bus.gcd_start, 1'b1);
    for (int i = 0; i < 4; i++) push(16'($urandom_range(0, 5000)), 16'($urandom_range(1, 5000)));
    check("fill_in_ready_low", bus.in_ready, 1'b0);
    check("fill_busy", bus.busy, 1'b1);
    wait_idle(400);
    check("fill_results", n_results - base_r, 5);

    // Result held while the consumer stalls
    cfg_compute = 3; cfg_done_w = 2;
    bus.out_ready = 1'b0;
    push(16'd100, 16'd75);
    push(16'd21, 16'd14);
    wait_valid(60);
    held_g = bus.out_gcd;
    check("hold_first_gcd", held_g, 16'd25);
    base_s = n_starts;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_out_gcd",   bus.out_gcd,   held_g);
    end
    check("hold_no_start", n_starts, base_s);
    bus.out_ready = 1'b1;
    wait_idle(100);
    check("hold_second_start", n_starts, base_s + 1);

    // Wide done pulse yields one result each
    cfg_compute = 2; cfg_done_w = 4;
    base_r = n_results;
    push(16'd0, 16'd9);
    push(16'd35, 16'd49);
    wait_idle(100);
    check("wide_done_results", n_results - base_r, 2);

    // Asynchronous reset while WAIT_DONE with two entries queued
    cfg_compute = 8; cfg_done_w = 2;
    push(16'd30, 16'd12);
    push(16'd8, 16'd4);
    push(16'd9, 16'd6);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gcd_start", bus.gcd_start, 1'b0);
    check("arst_gcd_a",     bus.gcd_a,     '0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_busy",      bus.busy,      1'b0);
    check("arst_in_ready",  bus.in_ready,  1'b1);
    exp_q.delete();
    base_r = n_results;
    base_s = n_starts;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("arst_no_result", n_results, base_r);
    check("arst_no_start",  n_starts,  base_s);
    check("arst_idle_busy", bus.busy,  1'b0);

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    base_r = n_results;
    for (int i = 0; i < 40; i++) begin
      cfg_compute = $urandom_range(0, 6);
      cfg_done_w  = $urandom_range(1, 4);
      k  = $urandom_range(1, 12);
      ra = 16'(k * $urandom_range(0, 300));
      rb = 16'(k * $urandom_range(0, 300));
      push(ra, rb);
      tick($urandom_range(0, 3));
    end
    wait_idle(3000);
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    check("rand_results", n_results - base_r, 40);

`ifdef GCD_REQ_TIMEOUT_EN
    // Done never arrives: abort after TIMEOUT WAIT_DONE cycles
    cfg_never = 1'b1;
    push(16'd7, 16'd5);
    tick(1);
    check("to_start", bus.gcd_start, 1'b1);
    tick(TIMEOUT);
    check("to_not_early", bus.out_valid, 1'b0);
    tick(1);
    check("to_out_valid", bus.out_valid, 1'b1);
    check("to_out_err",   bus.out_err,   1'b1);
    check("to_out_gcd",   bus.out_gcd,   '0);
    check("to_out_a",     bus.out_a,     16'd7);
    check("to_out_b",     bus.out_b,     16'd5);
    wait_idle(50);
    cfg_never = 1'b0;
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
